// File: rtl/prog_loader_if.sv
// Byte stream in, instruction-memory write bus out, bundled for the program loader.
// The slave modport is the loader's view; master is the surrounding system's view.
interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory as big-endian words,
// holding the CPU in reset until a complete, verified program has been written.
module prog_loader #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    prog_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);

    localparam int          IDX_W     = DEPTH_LOG2 + 1;
    localparam logic [16:0] MAX_WORDS = 17'(1) << DEPTH_LOG2;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    state_t           state;
    logic [7:0]       count_hi;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] last_idx;
    logic [1:0]       byte_cnt;
    logic [7:0]       sum;
    logic [23:0]      partial;
    logic             ready_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic             accept;
    logic [16:0]      count_n;

    assign accept  = bus.in_valid && ready_q;
    assign count_n = {1'b0, count_hi, bus.in_data};

    assign bus.in_ready   = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HDR_HI;
            count_hi  <= 8'd0;
            word_idx  <= '0;
            last_idx  <= '0;
            byte_cnt  <= 2'd0;
            sum       <= 8'd0;
            partial   <= 24'd0;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state)
                HDR_HI: begin
                    if (accept) begin
                        count_hi <= bus.in_data;
                        state    <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        // Storing N-1 lets the last-word test compare against the current index.
                        last_idx <= IDX_W'(count_n - 17'd1);
                        if (count_n == 17'd0) begin
                            state <= CSUM;
                        end else if (count_n > MAX_WORDS) begin
                            state   <= ERROR;
                            ready_q <= 1'b0;
                            error   <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        sum      <= sum + bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            we_q     <= 1'b1;
                            addr_q   <= 32'({word_idx, 2'b00});
                            wdata_q  <= {partial, bus.in_data};
                            word_idx <= word_idx + IDX_W'(1);
                            if (word_idx == last_idx) begin
                                state <= CSUM;
                            end
                        end else begin
                            partial <= {partial[15:0], bus.in_data};
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (bus.in_data == sum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (restart) begin
                        state     <= HDR_HI;
                        word_idx  <= '0;
                        byte_cnt  <= 2'd0;
                        sum       <= 8'd0;
                        partial   <= 24'd0;
                        ready_q   <= 1'b1;
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                default: begin
                    state <= HDR_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: good/bad checksum, empty and oversize programs,
// maximum-size program, throttled input, mid-load reset and restart.
module tb_prog_loader;

    logic clk;
    logic reset;
    logic restart;
    logic cpu_reset;
    logic done;
    logic error;

    prog_loader_if bus ();

    prog_loader #(.DEPTH_LOG2(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  stim_q[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic        pre_cpu_reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log sampled mid-cycle, with a cycle stamp for latency checks.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearLog();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    // Sends stim_q, optionally with random idle cycles; pre_cpu_reset captures cpu_reset
    // in the cycle the final byte is presented.
    task automatic applyStimulus(input bit gaps);
        int waited;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 0) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = stim_q[i];
            waited = 0;
            while (!bus.in_ready && waited < 50) begin
                @(posedge clk);
                #1;
                waited++;
            end
            if (!bus.in_ready) begin
                checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
                break;
            end
            pre_cpu_reset = cpu_reset;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic doReset();
        reset        = 1'b1;
        restart      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        clearLog();
    endtask

    initial begin
        logic [31:0] exp_word;
        int          bad;

        reset        = 1'b1;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_imem_we",    32'(bus.imem_we), 32'd0);
        checkOutput("rst_imem_addr",  bus.imem_addr,    32'd0);
        checkOutput("rst_imem_wdata", bus.imem_wdata,   32'd0);
        checkOutput("rst_cpu_reset",  32'(cpu_reset),   32'd1);
        checkOutput("rst_done",       32'(done),        32'd0);
        checkOutput("rst_error",      32'(error),       32'd0);
        reset = 1'b0;
        checkOutput("rst_in_ready",   32'(bus.in_ready), 32'd1);

        $display("[TB] two-word program, back-to-back");
        stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00, 8'h35};
        applyStimulus(1'b0);
        checkOutput("a_wr_count",   32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            checkOutput("a_addr0",  wr_addr[0], 32'h0000_0000);
            checkOutput("a_data0",  wr_data[0], 32'h2008_0005);
            checkOutput("a_addr1",  wr_addr[1], 32'h0000_0004);
            checkOutput("a_data1",  wr_data[1], 32'h0800_0000);
            checkOutput("a_wr_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
        end
        checkOutput("a_cpu_reset_pre", 32'(pre_cpu_reset), 32'd1);
        checkOutput("a_cpu_reset",     32'(cpu_reset),     32'd0);
        checkOutput("a_done",          32'(done),          32'd1);
        checkOutput("a_error",         32'(error),         32'd0);
        checkOutput("a_in_ready",      32'(bus.in_ready),  32'd0);

        $display("[TB] bad checksum");
        doReset();
        stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00, 8'h36};
        applyStimulus(1'b0);
        checkOutput("b_error",     32'(error),         32'd1);
        checkOutput("b_done",      32'(done),          32'd0);
        checkOutput("b_cpu_reset", 32'(cpu_reset),     32'd1);
        checkOutput("b_in_ready",  32'(bus.in_ready),  32'd0);

        $display("[TB] empty program");
        doReset();
        stim_q = '{8'h00, 8'h00, 8'h00};
        applyStimulus(1'b0);
        checkOutput("e_wr_count", 32'(wr_addr.size()), 32'd0);
        checkOutput("e_done",     32'(done),           32'd1);
        checkOutput("e_cpu_reset", 32'(cpu_reset),     32'd0);

        $display("[TB] oversize program");
        doReset();
        stim_q = '{8'h01, 8'h01};
        applyStimulus(1'b0);
        checkOutput("o_error",    32'(error),          32'd1);
        checkOutput("o_in_ready", 32'(bus.in_ready),   32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("o_wr_count", 32'(wr_addr.size()), 32'd0);

        $display("[TB] maximum-size program (256 words)");
        doReset();
        stim_q = '{8'h01, 8'h00};
        for (int i = 0; i < 1024; i++) stim_q.push_back(i[7:0]);
        stim_q.push_back(8'h00);
        applyStimulus(1'b0);
        checkOutput("m_wr_count", 32'(wr_addr.size()), 32'd256);
        bad = 0;
        for (int k = 0; k < wr_addr.size(); k++) begin
            exp_word = {k[5:0], 2'd0, k[5:0], 2'd1, k[5:0], 2'd2, k[5:0], 2'd3};
            if (wr_addr[k] !== 32'(k * 4) || wr_data[k] !== exp_word) bad++;
        end
        checkOutput("m_words_bad", 32'(bad), 32'd0);
        checkOutput("m_done",      32'(done), 32'd1);

        $display("[TB] two-word program, throttled input");
        doReset();
        stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00, 8'h35};
        applyStimulus(1'b1);
        checkOutput("r_wr_count", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            checkOutput("r_addr0", wr_addr[0], 32'h0000_0000);
            checkOutput("r_data0", wr_data[0], 32'h2008_0005);
            checkOutput("r_addr1", wr_addr[1], 32'h0000_0004);
            checkOutput("r_data1", wr_data[1], 32'h0800_0000);
        end
        checkOutput("r_done",      32'(done),      32'd1);
        checkOutput("r_cpu_reset", 32'(cpu_reset), 32'd0);

        $display("[TB] reset during a partial word");
        doReset();
        stim_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        applyStimulus(1'b0);
        checkOutput("p_cpu_reset_mid", 32'(cpu_reset), 32'd1);
        doReset();
        checkOutput("p_wr_after_reset", 32'(wr_addr.size()), 32'd0);
        stim_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
        applyStimulus(1'b0);
        checkOutput("p_wr_count", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            checkOutput("p_addr0", wr_addr[0], 32'h0000_0000);
            checkOutput("p_data0", wr_data[0], 32'hDEAD_BEEF);
        end
        checkOutput("p_done", 32'(done), 32'd1);

        $display("[TB] restart from DONE, restart ignored mid-load");
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        clearLog();
        checkOutput("s_cpu_reset", 32'(cpu_reset),    32'd1);
        checkOutput("s_done",      32'(done),         32'd0);
        checkOutput("s_in_ready",  32'(bus.in_ready), 32'd1);
        stim_q = '{8'h00, 8'h01, 8'hDE};
        applyStimulus(1'b0);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        stim_q = '{8'hAD, 8'hBE, 8'hEF, 8'h38};
        applyStimulus(1'b0);
        checkOutput("s_wr_count", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            checkOutput("s_addr0", wr_addr[0], 32'h0000_0000);
            checkOutput("s_data0", wr_data[0], 32'hDEAD_BEEF);
        end
        checkOutput("s_done_again", 32'(done),      32'd1);
        checkOutput("s_cpu_run",    32'(cpu_reset), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
